// File: rtl/aibio_pi_phsel_pkg.sv
// Shared constants, the step-direction type and the direction function for the
// phase-interpolator phase-select sequencer.
// Pure definitions: no ports, no state, no clocking.
package aibio_pi_phsel_pkg;

  localparam int NCH_DEF = 2;  // channels (even/odd)
  localparam int NPH_DEF = 4;  // phases per bank, power of two, >= 2

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2
  } step_dir_e;

  // Shortest way round the code ring of p positions. An exact half-ring
  // distance is resolved upward so the choice is deterministic.
  function automatic step_dir_e step_dir(input int unsigned cur,
                                         input int unsigned tgt,
                                         input int unsigned p);
    int unsigned diff;
    diff = (tgt + p - cur) % p;
    if (diff == 0)
      return STEP_NONE;
    else if (diff <= p / 2)
      return STEP_UP;
    else
      return STEP_DN;
  endfunction

endpackage

// File: rtl/aibio_pi_phsel_chan.sv
// One phase-select channel: target register, interval counter, walker, decoder.
// Latency: a step lands step_ivl+1 cycles after the load edge; done one cycle after arrival.
// Backpressure: none; a new target replaces the old one at any time, freeze holds the walk.
// Ports: clk/rst_n; tgt_vld/tgt_code load the target; step_ivl, jump_mode, freeze are
// shared controls; phsel_stg1/phsel_stg2/code/busy/done are registered outputs.
module aibio_pi_phsel_chan
  import aibio_pi_phsel_pkg::*;
#(
  parameter  int NPH = NPH_DEF,
  localparam int P   = 2 * NPH,
  localparam int CW  = $clog2(P)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tgt_vld,
  input  logic [CW-1:0]  tgt_code,
  input  logic [3:0]     step_ivl,
  input  logic           jump_mode,
  input  logic           freeze,
  output logic [NPH-1:0] phsel_stg1,
  output logic           phsel_stg2,
  output logic [CW-1:0]  code,
  output logic           busy,
  output logic           done
);

  logic [CW-1:0] cur_q, cur_d, tgt_q, tgt_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_d, done_d;
  // Set by every load, cleared when the matching done is reported; this is
  // what lets a load equal to the current code still produce a done pulse,
  // and keeps a mid-walk retarget down to a single done.
  logic          arm_q, arm_d;
  step_dir_e     dir;

  always_comb begin
    // Stepping always follows the registered target, so a load never moves
    // the code on its own edge.
    dir    = step_dir(32'(cur_q), 32'(tgt_q), 32'(P));
    tgt_d  = tgt_vld ? tgt_code : tgt_q;
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    busy_d = busy;
    done_d = 1'b0;
    arm_d  = arm_q;
    if (!freeze) begin
      if (dir == STEP_NONE) begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (arm_q) begin
          done_d = 1'b1;
          arm_d  = 1'b0;
        end
      end else if (jump_mode) begin
        // Land directly and report completion together with the new code.
        cur_d  = tgt_q;
        cnt_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
        arm_d  = 1'b0;
      end else begin
        busy_d = 1'b1;
        if (cnt_q == step_ivl) begin
          cnt_d = '0;
          // CW-bit arithmetic wraps the ring for free since P is 2**CW.
          cur_d = (dir == STEP_UP) ? cur_q + CW'(1) : cur_q - CW'(1);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end
    if (tgt_vld)
      arm_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= '0;
      tgt_q      <= '0;
      cnt_q      <= '0;
      arm_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      phsel_stg1 <= NPH'(1);
      phsel_stg2 <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      arm_q      <= arm_d;
      busy       <= busy_d;
      done       <= done_d;
      // Decode from the next code so the selects are registered and stay
      // aligned with the code output.
      phsel_stg1 <= NPH'(1) << cur_d[CW-2:0];
      phsel_stg2 <= cur_d[CW-1];
    end
  end

  assign code = cur_q;

endmodule

// File: rtl/aibio_pi_phsel_seq.sv
// Multi-channel phase-interpolator phase-select sequencer (NCH independent walkers).
// Latency: outputs registered; step every i_step_ivl+1 cycles, jump lands one cycle after load.
// Backpressure: none; i_freeze holds all codes and counters, loads are still captured.
// Ports: i_clk/i_rst_n; per-channel i_tgt_vld/i_tgt_code; shared i_step_ivl, i_jump_mode,
// i_freeze; per-channel o_phsel_stg1 (one-hot), o_phsel_stg2, o_code, o_busy, o_done.
module aibio_pi_phsel_seq
  import aibio_pi_phsel_pkg::*;
#(
  parameter  int NCH = NCH_DEF,
  parameter  int NPH = NPH_DEF,
  localparam int P   = 2 * NPH,
  localparam int CW  = $clog2(P)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NCH-1:0]     i_tgt_vld,
  input  logic [NCH*CW-1:0]  i_tgt_code,
  input  logic [3:0]         i_step_ivl,
  input  logic               i_jump_mode,
  input  logic               i_freeze,
  output logic [NCH*NPH-1:0] o_phsel_stg1,
  output logic [NCH-1:0]     o_phsel_stg2,
  output logic [NCH*CW-1:0]  o_code,
  output logic [NCH-1:0]     o_busy,
  output logic [NCH-1:0]     o_done
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    aibio_pi_phsel_chan #(.NPH(NPH)) u_chan (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .tgt_vld    (i_tgt_vld[c]),
      .tgt_code   (i_tgt_code[c*CW +: CW]),
      .step_ivl   (i_step_ivl),
      .jump_mode  (i_jump_mode),
      .freeze     (i_freeze),
      .phsel_stg1 (o_phsel_stg1[c*NPH +: NPH]),
      .phsel_stg2 (o_phsel_stg2[c]),
      .code       (o_code[c*CW +: CW]),
      .busy       (o_busy[c]),
      .done       (o_done[c])
    );
  end

endmodule

// File: tb/tb_aibio_pi_phsel_seq.sv
// Directed bench for aibio_pi_phsel_seq with a per-cycle expectation scoreboard.
module tb_aibio_pi_phsel_seq;

  localparam int NCH = 2;
  localparam int NPH = 4;
  localparam int CW  = 3;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic [NCH-1:0]     i_tgt_vld;
  logic [NCH*CW-1:0]  i_tgt_code;
  logic [3:0]         i_step_ivl;
  logic               i_jump_mode;
  logic               i_freeze;
  logic [NCH*NPH-1:0] o_phsel_stg1;
  logic [NCH-1:0]     o_phsel_stg2;
  logic [NCH*CW-1:0]  o_code;
  logic [NCH-1:0]     o_busy;
  logic [NCH-1:0]     o_done;

  aibio_pi_phsel_seq #(.NCH(NCH), .NPH(NPH)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_tgt_vld    (i_tgt_vld),
    .i_tgt_code   (i_tgt_code),
    .i_step_ivl   (i_step_ivl),
    .i_jump_mode  (i_jump_mode),
    .i_freeze     (i_freeze),
    .o_phsel_stg1 (o_phsel_stg1),
    .o_phsel_stg2 (o_phsel_stg2),
    .o_code       (o_code),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         ch;
    logic [2:0] code;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int ch, input logic [2:0] code, input logic busy,
                      input logic done, input string tag);
    exp_t e;
    e.ch = ch; e.code = code; e.busy = busy; e.done = done; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [3:0] oh;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      oh = 4'b0001 << e.code[1:0];
      chk({e.tag, "/code"}, 32'(o_code[e.ch*CW +: CW]),        32'(e.code));
      chk({e.tag, "/busy"}, 32'(o_busy[e.ch]),                 32'(e.busy));
      chk({e.tag, "/done"}, 32'(o_done[e.ch]),                 32'(e.done));
      chk({e.tag, "/stg1"}, 32'(o_phsel_stg1[e.ch*NPH +: NPH]), 32'(oh));
      chk({e.tag, "/stg2"}, 32'(o_phsel_stg2[e.ch]),           32'(e.code[2]));
    end
  endtask

  // Inputs change #1 after a rising edge, outputs are sampled at the same point.
  task automatic tick();
    @(posedge i_clk);
    #1;
    i_tgt_vld = '0;
    drain();
  endtask

  task automatic load(input int ch, input logic [2:0] code);
    i_tgt_vld[ch] = 1'b1;
    i_tgt_code[ch*CW +: CW] = code;
  endtask

  // Expect channel 0 state after the next edge.
  task automatic s0(input logic [2:0] code, input logic busy, input logic done,
                    input string tag);
    push(0, code, busy, done, tag);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n     = 1'b0;
    i_tgt_vld   = '0;
    i_tgt_code  = '0;
    i_step_ivl  = 4'd0;
    i_jump_mode = 1'b0;
    i_freeze    = 1'b0;

    // Reset values.
    repeat (2) @(posedge i_clk);
    #1;
    push(0, 3'd0, 1'b0, 1'b0, "rst_ch0");
    push(1, 3'd0, 1'b0, 1'b0, "rst_ch1");
    drain();
    i_rst_n = 1'b1;

    // Walk 0->3 on ch0 and 0->2 on ch1 at ivl=0.
    load(0, 3'd3); load(1, 3'd2);
    push(1, 3'd0, 1'b0, 1'b0, "w3_e0_ch1"); s0(3'd0, 1'b0, 1'b0, "w3_e0");
    push(1, 3'd1, 1'b1, 1'b0, "w3_e1_ch1"); s0(3'd1, 1'b1, 1'b0, "w3_e1");
    push(1, 3'd2, 1'b1, 1'b0, "w3_e2_ch1"); s0(3'd2, 1'b1, 1'b0, "w3_e2");
    push(1, 3'd2, 1'b0, 1'b1, "w3_e3_ch1"); s0(3'd3, 1'b1, 1'b0, "w3_e3");
    chk("w3_stg1_lit", 32'(o_phsel_stg1[3:0]), 32'h8);
    chk("w3_stg2_lit", 32'(o_phsel_stg2[0]), 32'h0);
    push(1, 3'd2, 1'b0, 1'b0, "w3_e4_ch1"); s0(3'd3, 1'b0, 1'b1, "w3_e4");
    s0(3'd3, 1'b0, 1'b0, "w3_e5");

    // 3 -> 1 walks down, then 1 -> 7 walks down through the wrap.
    load(0, 3'd1);
    s0(3'd3, 1'b0, 1'b0, "d1_e0");
    s0(3'd2, 1'b1, 1'b0, "d1_e1");
    s0(3'd1, 1'b1, 1'b0, "d1_e2");
    s0(3'd1, 1'b0, 1'b1, "d1_e3");
    load(0, 3'd7);
    s0(3'd1, 1'b0, 1'b0, "wr_e0");
    s0(3'd0, 1'b1, 1'b0, "wr_e1");
    s0(3'd7, 1'b1, 1'b0, "wr_e2");
    s0(3'd7, 1'b0, 1'b1, "wr_e3");

    // 7 -> 0 wraps up, then ivl=3, 0 -> 2: steps at +4 and +8, done at +9.
    load(0, 3'd0);
    s0(3'd7, 1'b0, 1'b0, "u0_e0");
    s0(3'd0, 1'b1, 1'b0, "u0_e1");
    s0(3'd0, 1'b0, 1'b1, "u0_e2");
    i_step_ivl = 4'd3;
    load(0, 3'd2);
    s0(3'd0, 1'b0, 1'b0, "iv_e0");
    for (int k = 1; k <= 3; k++) s0(3'd0, 1'b1, 1'b0, "iv_pre1");
    for (int k = 4; k <= 7; k++) s0(3'd1, 1'b1, 1'b0, "iv_at1");
    s0(3'd2, 1'b1, 1'b0, "iv_e8");
    s0(3'd2, 1'b0, 1'b1, "iv_e9");
    s0(3'd2, 1'b0, 1'b0, "iv_e10");

    // Jump mode: 2 -> 6 in one cycle with done alongside.
    i_step_ivl  = 4'd0;
    i_jump_mode = 1'b1;
    load(0, 3'd6);
    s0(3'd2, 1'b0, 1'b0, "jp_e0");
    s0(3'd6, 1'b0, 1'b1, "jp_e1");
    chk("jp_stg1_lit", 32'(o_phsel_stg1[3:0]), 32'h4);
    chk("jp_stg2_lit", 32'(o_phsel_stg2[0]), 32'h1);
    s0(3'd6, 1'b0, 1'b0, "jp_e2");
    i_jump_mode = 1'b0;

    // 6 -> 0 up via wrap; then ivl=1, 0 -> 4 (half-ring tie goes up),
    // retargeted to 1 at code 2 between steps.
    load(0, 3'd0);
    s0(3'd6, 1'b0, 1'b0, "r0_e0");
    s0(3'd7, 1'b1, 1'b0, "r0_e1");
    s0(3'd0, 1'b1, 1'b0, "r0_e2");
    s0(3'd0, 1'b0, 1'b1, "r0_e3");
    i_step_ivl = 4'd1;
    load(0, 3'd4);
    s0(3'd0, 1'b0, 1'b0, "rt_e0");
    s0(3'd0, 1'b1, 1'b0, "rt_e1");
    s0(3'd1, 1'b1, 1'b0, "rt_e2");
    s0(3'd1, 1'b1, 1'b0, "rt_e3");
    s0(3'd2, 1'b1, 1'b0, "rt_e4");
    load(0, 3'd1);
    s0(3'd2, 1'b1, 1'b0, "rt_e5");
    s0(3'd1, 1'b1, 1'b0, "rt_e6");
    s0(3'd1, 1'b0, 1'b1, "rt_e7");
    s0(3'd1, 1'b0, 1'b0, "rt_e8");
    s0(3'd1, 1'b0, 1'b0, "rt_e9");

    // Freeze mid-walk for 5 cycles, resume, then reset mid-walk.
    i_step_ivl = 4'd0;
    load(0, 3'd5);
    s0(3'd1, 1'b0, 1'b0, "fz_e0");
    s0(3'd2, 1'b1, 1'b0, "fz_e1");
    i_freeze = 1'b1;
    for (int k = 0; k < 5; k++) s0(3'd2, 1'b1, 1'b0, "fz_hold");
    i_freeze = 1'b0;
    s0(3'd3, 1'b1, 1'b0, "fz_resume");
    #2;
    i_rst_n = 1'b0;
    #1;
    push(0, 3'd0, 1'b0, 1'b0, "mrst_ch0");
    push(1, 3'd0, 1'b0, 1'b0, "mrst_ch1");
    drain();
    for (int k = 0; k < 3; k++) begin
      push(1, 3'd0, 1'b0, 1'b0, "inrst_ch1");
      s0(3'd0, 1'b0, 1'b0, "inrst_ch0");
    end
    i_rst_n = 1'b1;
    s0(3'd0, 1'b0, 1'b0, "post_rst");
    s0(3'd0, 1'b0, 1'b0, "post_rst2");

    // Load equal to the current code: no walk, done one cycle later.
    load(0, 3'd0);
    s0(3'd0, 1'b0, 1'b0, "eq_e0");
    s0(3'd0, 1'b0, 1'b1, "eq_e1");
    s0(3'd0, 1'b0, 1'b0, "eq_e2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aibio_pi_phsel_seq.md
AIBIO_PI_PHSEL_SEQ -- requirements
Module: aibio_pi_phsel_seq

Interface
REQ-001 The module SHALL have parameter NCH, default 2, giving the number of independent phase-select channels (2 = even/odd).
REQ-002 The module SHALL have parameter NPH, default 4, giving the phases per bank; NPH SHALL be a power of two and at least 2.
REQ-003 The module SHALL define derived constants P = 2*NPH (code positions) and CW = $clog2(P) (code width).
REQ-004 The module SHALL have a single clock and an asynchronous, active-low reset.
REQ-005 i_clk  input  1  sequencer clock.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_tgt_vld  input  NCH  per-channel one-cycle pulse that loads the target code.
REQ-008 i_tgt_code  input  NCH*CW  per-channel target phase code; channel c occupies bits [c*CW +: CW].
REQ-009 i_step_ivl  input  4  cycles between steps, minus one; shared by all channels.
REQ-010 i_jump_mode  input  1  1 = load the target directly, with no walking.
REQ-011 i_freeze  input  1  holds every code and interval counter.
REQ-012 o_phsel_stg1  output  NCH*NPH  per-channel one-hot stage-1 phase select.
REQ-013 o_phsel_stg2  output  NCH  per-channel stage-2 select (0 = even bank, 1 = odd bank).
REQ-014 o_code  output  NCH*CW  current per-channel code.
REQ-015 o_busy  output  NCH  high while the current code differs from the target code.
REQ-016 o_done  output  NCH  one-cycle pulse when the current code reaches the target code.

Function
REQ-017 Code encoding SHALL be: code[CW-1] drives stg2, and code[CW-2:0] selects the one-hot stg1 bit; positions 0..NPH-1 are the even bank and NPH..P-1 are the odd bank.
REQ-018 All outputs SHALL be registered; o_phsel_stg1 and o_phsel_stg2 SHALL be decoded from the registered code, and stg1 SHALL be exactly one-hot at all times.
REQ-019 A pulse on i_tgt_vld[c] SHALL load tgt[c] on that edge; if the channel is busy, the new target replaces the old one and the interval counter is not reset.
REQ-020 Walk mode: while cur != tgt, the channel SHALL change cur by exactly ±1 (mod P) each time its interval counter reaches i_step_ivl; the counter then clears.
REQ-021 Direction SHALL be: diff = (tgt - cur) mod P; step up if 1 <= diff <= P/2, otherwise step down; the tie at P/2 steps up.
REQ-022 Wrap-around SHALL be seamless: up from P-1 gives 0, and down from 0 gives P-1.
REQ-023 With i_step_ivl = 0, the channel SHALL step on every cycle; with i_step_ivl = N, it SHALL step once every N+1 cycles.
REQ-024 The first step after a load SHALL occur i_step_ivl+1 cycles after the load edge when the channel was idle (the counter holds 0 when idle).
REQ-025 Jump mode (i_jump_mode = 1): cur SHALL equal tgt one cycle after the load, and o_done SHALL pulse in that same cycle.
REQ-026 A load with tgt == cur SHALL produce no step, o_busy SHALL stay 0, and o_done SHALL pulse one cycle later.
REQ-027 i_freeze = 1 SHALL hold cur, the counters and o_busy; target loads are still captured; o_done SHALL not pulse while frozen.
REQ-028 o_done[c] SHALL pulse in the cycle after cur[c] becomes equal to tgt[c]; o_busy[c] SHALL fall in the same cycle.
REQ-029 Channels SHALL be fully independent apart from the shared i_step_ivl, i_jump_mode and i_freeze.

Reset
REQ-030 On i_rst_n low, all of the following SHALL clear asynchronously: cur = 0, tgt = 0, counters = 0, o_busy = 0, o_done = 0.
REQ-031 During reset, o_phsel_stg1 SHALL be bit 0 set per channel and o_phsel_stg2 SHALL be 0.
REQ-032 Reset deassertion SHALL be synchronous to i_clk; the first load is accepted on the first edge after deassertion.
REQ-033 Reset asserted mid-walk SHALL abandon the walk; no o_done pulse is generated.

Structure
REQ-034 Package aibio_pi_phsel_pkg SHALL hold the NCH and NPH defaults, the step-direction enum (STEP_NONE, STEP_UP, STEP_DN), and the direction function.
REQ-035 Sub-module aibio_pi_phsel_chan SHALL implement one channel (target register, interval counter, walker and decoder).
REQ-036 The top level SHALL instantiate aibio_pi_phsel_chan NCH times via generate.

Verification
REQ-037 Reset release, then load ch0 = 3, ivl = 0, walk mode -> codes 1, 2, 3 on consecutive cycles; o_done[0] pulses once; stg1 = 4'b1000, stg2 = 0.
REQ-038 cur = 1, load 7, P = 8 -> walks down 1, 0, 7, wrapping; o_busy is high throughout.
REQ-039 ivl = 3, load 2 from 0 -> steps at cycles +4 and +8; o_done pulses at cycle +9.
REQ-040 Jump mode, load 6 -> code = 6, stg2 = 1, stg1 = 4'b0100 the next cycle, with o_done in the same cycle.
REQ-041 Retarget mid-walk (0 -> 4, then at code 2 load 1) -> reverses direction to 1; only one o_done pulse.
REQ-042 i_freeze high mid-walk for 5 cycles, then reset asserted mid-walk -> code held while frozen; after reset all outputs at reset values, with no o_done.
